// File: rtl/bus_arb3_if.sv
// Shared-bus arbitration handshake between the three requesters and bus_arb3.
// The arbiter uses the slave modport; requester-side logic or a testbench uses master.
interface bus_arb3_if;
  logic [2:0] REQ;
  logic       DONE;
  logic [2:0] GNT;
  logic [1:0] OWNER;
  logic       BUSY;
  logic       TMO;

  modport slave  (input  REQ, DONE, output GNT, OWNER, BUSY, TMO);
  modport master (output REQ, DONE, input  GNT, OWNER, BUSY, TMO);
endinterface

// File: rtl/bus_arb3.sv
// Three-way round-robin bus arbiter with a one-cycle dead slot between owners
// and a hold-time watchdog that revokes grants held longer than TIMEOUT cycles.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no owner; arbitrate on REQ every cycle
// S_GRANT   | one owner drives the bus; watch DONE, REQ[owner] and the hold count
// S_RELEASE | dead cycle after a grant; arbitrate for the next owner
module bus_arb3 #(
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  bus_arb3_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [2:0] gnt_q,   gnt_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q,  busy_d;
  logic       tmo_q,   tmo_d;

  logic [1:0] cand1, cand2, win;
  logic       any_req;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign cand1   = inc3(ptr_q);
  assign cand2   = inc3(cand1);
  assign any_req = |bus.REQ;

  // Later assignments override earlier ones, so ptr_q has highest priority.
  always_comb begin
    win = cand2;
    if (bus.REQ[cand1]) win = cand1;
    if (bus.REQ[ptr_q]) win = ptr_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;

    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (any_req) begin
          state_d = S_GRANT;
          gnt_d   = 3'b001 << win;
          owner_d = win;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          ptr_d   = inc3(win);
        end else begin
          state_d = S_IDLE;
          gnt_d   = 3'b000;
          owner_d = 2'd0;
          busy_d  = 1'b0;
        end
      end
      S_GRANT: begin
        if (bus.DONE || !bus.REQ[owner_q] || (cnt_q == CNT_LAST)) begin
          state_d = S_RELEASE;
          gnt_d   = 3'b000;
          owner_d = 2'd0;
          busy_d  = 1'b0;
          // Watchdog flagged only when neither completion nor withdrawal explains the release.
          tmo_d   = !bus.DONE && bus.REQ[owner_q];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        owner_d = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 3'b000;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.OWNER = owner_q;
  assign bus.BUSY  = busy_q;
  assign bus.TMO   = tmo_q;

endmodule

// File: tb/tb_bus_arb3.sv
// Self-checking bench for bus_arb3: directed vector table, hand-written corner
// sequences, then randomized traffic against an owner/hold-count reference model.
module tb_bus_arb3;

  logic clk;
  logic rst;

  bus_arb3_if bus0 ();
  bus_arb3_if bus1 ();

  bus_arb3 #(.TIMEOUT(15)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  bus_arb3 #(.TIMEOUT(1))  dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 when nobody holds the bus), cycles held so far, pointer.
  int         m_owner [2];
  int         m_held  [2];
  int         m_ptr   [2];
  logic [2:0] e_gnt   [2];
  logic [1:0] e_owner [2];
  logic       e_busy  [2];
  logic       e_tmo   [2];

  task automatic model_step(input int m, input int lim, input logic r,
                            input logic [2:0] req, input logic done);
    logic t;
    bit   picked;
    t = 1'b0;
    if (r) begin
      m_owner[m] = -1;
      m_held[m]  = 0;
      m_ptr[m]   = 0;
    end else if (m_owner[m] < 0) begin
      picked = 0;
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr[m] + k) % 3;
        if (!picked && req[idx]) begin
          picked     = 1;
          m_owner[m] = idx;
          m_held[m]  = 1;
        end
      end
      if (picked) m_ptr[m] = (m_owner[m] + 1) % 3;
    end else begin
      if (done || !req[m_owner[m]]) begin
        m_owner[m] = -1;
      end else if (m_held[m] == lim) begin
        m_owner[m] = -1;
        t = 1'b1;
      end else begin
        m_held[m] = m_held[m] + 1;
      end
    end
    e_tmo[m]   = t;
    e_busy[m]  = (m_owner[m] >= 0);
    e_gnt[m]   = (m_owner[m] >= 0) ? 3'(1 << m_owner[m]) : 3'b000;
    e_owner[m] = (m_owner[m] >= 0) ? 2'(m_owner[m]) : 2'd0;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] g, input logic [1:0] o,
                         input logic b, input logic t);
    chk({nm, ".gnt"},   8'(bus0.GNT),   8'(g));
    chk({nm, ".owner"}, 8'(bus0.OWNER), 8'(o));
    chk({nm, ".busy"},  8'(bus0.BUSY),  8'(b));
    chk({nm, ".tmo"},   8'(bus0.TMO),   8'(t));
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".t15.gnt"},   8'(bus0.GNT),   8'(e_gnt[0]));
    chk({nm, ".t15.owner"}, 8'(bus0.OWNER), 8'(e_owner[0]));
    chk({nm, ".t15.busy"},  8'(bus0.BUSY),  8'(e_busy[0]));
    chk({nm, ".t15.tmo"},   8'(bus0.TMO),   8'(e_tmo[0]));
    chk({nm, ".t1.gnt"},    8'(bus1.GNT),   8'(e_gnt[1]));
    chk({nm, ".t1.owner"},  8'(bus1.OWNER), 8'(e_owner[1]));
    chk({nm, ".t1.busy"},   8'(bus1.BUSY),  8'(e_busy[1]));
    chk({nm, ".t1.tmo"},    8'(bus1.TMO),   8'(e_tmo[1]));
  endtask

  // Drive one cycle of inputs, advance one edge, then sample just after it.
  task automatic step(input logic r, input logic [2:0] req, input logic done);
    rst       = r;
    bus0.REQ  = req;
    bus1.REQ  = req;
    bus0.DONE = done;
    bus1.DONE = done;
    @(posedge clk);
    model_step(0, 15, r, req, done);
    model_step(1, 1,  r, req, done);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [2:0] rq;
    logic       dn, rr;

    rst = 1'b1; bus0.REQ = '0; bus1.REQ = '0; bus0.DONE = 1'b0; bus1.DONE = 1'b0;

    // Reset, idle, then full-request rotation with DONE in every grant cycle.
    vt[0] = '{1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    for (int i = 1; i <= 5; i++) vt[i] = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 3'b111, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'b111, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 3'b111, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
    vt[11] = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 3'b111, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst, vt[i].req, vt[i].done);
      chk_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].owner, vt[i].busy, vt[i].tmo);
    end

    // Watchdog: lone requester 1 holds for exactly 15 cycles, then TMO, then re-grant.
    step(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 3'b010, 1'b0);
      chk_all($sformatf("wd_hold%0d", i), 3'b010, 2'd1, 1'b1, 1'b0);
    end
    step(1'b0, 3'b010, 1'b0);
    chk_all("wd_tmo", 3'b000, 2'd0, 1'b0, 1'b1);
    step(1'b0, 3'b010, 1'b0);
    chk_all("wd_regrant", 3'b010, 2'd1, 1'b1, 1'b0);

    // DONE in the same cycle the watchdog would fire: DONE wins, no TMO.
    step(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 3'b001, 1'b0);
    chk_all("coll_last_hold", 3'b001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 3'b001, 1'b1);
    chk_all("coll_release", 3'b000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    chk_all("coll_idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Owner 2 withdraws after 3 cycles; pointer wraps to 0 so REQ=011 grants 0.
    step(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b100, 1'b0);
      chk_all($sformatf("drop_hold%0d", i), 3'b100, 2'd2, 1'b1, 1'b0);
    end
    step(1'b0, 3'b011, 1'b0);
    chk_all("drop_release", 3'b000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 3'b011, 1'b0);
    chk_all("drop_next", 3'b001, 2'd0, 1'b1, 1'b0);

    // Reset mid-grant clears everything including the pointer.
    step(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b100, 1'b0);
    chk_all("rst_pre", 3'b100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    chk_all("rst_mid", 3'b000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 3'b111, 1'b0);
    chk_all("rst_after", 3'b001, 2'd0, 1'b1, 1'b0);

    // Randomized traffic: mostly level-held requests, sporadic DONE and reset.
    rq = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      dn = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rq, dn);
      chk_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
